// File: rtl/sat_pkg.sv
// ---------------------------------------------------------------------------
// Module  : sat_pkg
// Purpose : Shared sizing constants and FSM state type for the clause scanner.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sat_pkg;

  // Base configuration
  localparam int NUM_CLAUSES           = 64;
  localparam int VAR_ID_BITS           = 8;
  localparam int NUM_CLAUSES_PER_CYCLE = 16;
  localparam int NUM_VARS_PER_CLAUSE   = 3;

  // Derived widths
  localparam int NUM_SLICES    = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;
  localparam int ADDR_BITS     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int MEMORY_WIDTH  = (VAR_ID_BITS + 1) * NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE;
  localparam int BITMASK_WIDTH = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE;
  localparam int CNT_BITS      = $clog2(NUM_CLAUSES * NUM_VARS_PER_CLAUSE + 1);

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bit_popcount.sv
// ---------------------------------------------------------------------------
// Module  : bit_popcount
// Purpose : Combinational population count of a WIDTH-bit vector.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bit_popcount #(
  parameter  int WIDTH      = 8,
  localparam int COUNT_BITS = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]      bits,
  output logic [COUNT_BITS-1:0] count
);

  // Sum every set bit; the count width always holds WIDTH without wrapping
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + COUNT_BITS'(bits[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/clause_scanner.sv
// ---------------------------------------------------------------------------
// Module  : clause_scanner
// Purpose : Latches one variable assignment, walks clause memory slice by
//           slice into the comparator, streams the falsified-literal masks
//           and reports the total falsified-literal count per scan.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module clause_scanner #(
  parameter  int NUM_CLAUSES           = sat_pkg::NUM_CLAUSES,
  parameter  int VAR_ID_BITS           = sat_pkg::VAR_ID_BITS,
  parameter  int NUM_CLAUSES_PER_CYCLE = sat_pkg::NUM_CLAUSES_PER_CYCLE,
  parameter  int NUM_VARS_PER_CLAUSE   = sat_pkg::NUM_VARS_PER_CLAUSE,
  localparam int NUM_SLICES    = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int ADDR_BITS     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1,
  localparam int MEMORY_WIDTH  = (VAR_ID_BITS + 1) * NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
  localparam int BITMASK_WIDTH = NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
  localparam int CNT_BITS      = $clog2(NUM_CLAUSES * NUM_VARS_PER_CLAUSE + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // assignment request
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [VAR_ID_BITS-1:0]           req_var_id,
  input  logic                             req_var_val,
  // clause memory read port
  output logic                             mem_rd_en,
  output logic [ADDR_BITS-1:0]             mem_rd_addr,
  input  logic [MEMORY_WIDTH-1:0]          mem_rd_data,
  // comparator interface
  output logic [VAR_ID_BITS-1:0]           cmp_var_id,
  output logic                             cmp_var_val,
  output logic [MEMORY_WIDTH-1:0]          cmp_memory_slice,
  input  logic [BITMASK_WIDTH-1:0]         cmp_bitmask,
  // result stream
  output logic                             res_valid,
  output logic [ADDR_BITS-1:0]             res_slice_idx,
  output logic [BITMASK_WIDTH-1:0]         res_bitmask,
  output logic [NUM_CLAUSES_PER_CYCLE-1:0] res_clause_hit,
  output logic                             res_last,
  output logic                             done,
  output logic [CNT_BITS-1:0]              hit_count
);

  import sat_pkg::state_e;
  import sat_pkg::IDLE;
  import sat_pkg::READ;
  import sat_pkg::DRAIN;
  import sat_pkg::DONE;

  localparam int                   POP_BITS  = $clog2(BITMASK_WIDTH + 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_SLICES - 1);

  // A partial final slice has no defined layout, so refuse to build one
  generate
    if ((NUM_CLAUSES % NUM_CLAUSES_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("clause_scanner: NUM_CLAUSES must be a multiple of NUM_CLAUSES_PER_CYCLE");
    end
  endgenerate

  state_e                state;
  state_e                next_state;
  logic                  accept;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [1:0]            drain_cnt;
  logic                  rd_pend;      // read data arrives this cycle
  logic [ADDR_BITS-1:0]  rd_pend_idx;
  logic                  s1_valid;     // cmp_memory_slice holds a fresh slice
  logic [ADDR_BITS-1:0]  s1_idx;
  logic [CNT_BITS-1:0]   acc;
  logic [POP_BITS-1:0]   pop_count;

  assign accept      = req_valid & req_ready;
  assign mem_rd_addr = rd_addr;
  assign hit_count   = acc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: READ walks every slice, DRAIN covers memory + S1 + S2 latency
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = READ;
      READ:    if (rd_addr == LAST_ADDR) next_state = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    req_ready = (state == IDLE);
    mem_rd_en = (state == READ);
    done      = (state == DONE);
  end

  // Read address stepping and drain-cycle counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        rd_addr <= '0;
      end else if (state == READ && rd_addr != LAST_ADDR) begin
        rd_addr <= rd_addr + 1'b1;
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                drain_cnt <= '0;
    end
  end

  // Latch the assignment on accept and hold it for the whole scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_var_id  <= '0;
      cmp_var_val <= 1'b0;
    end else if (accept) begin
      cmp_var_id  <= req_var_id;
      cmp_var_val <= req_var_val;
    end
  end

  // S1: capture memory data one cycle after the strobe; slice is otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend          <= 1'b0;
      rd_pend_idx      <= '0;
      s1_valid         <= 1'b0;
      s1_idx           <= '0;
      cmp_memory_slice <= '0;
    end else begin
      rd_pend     <= mem_rd_en;
      rd_pend_idx <= rd_addr;
      s1_valid    <= rd_pend;
      if (rd_pend) begin
        s1_idx           <= rd_pend_idx;
        cmp_memory_slice <= mem_rd_data;
      end
    end
  end

  bit_popcount #(
    .WIDTH (BITMASK_WIDTH)
  ) u_popcount (
    .bits  (cmp_bitmask),
    .count (pop_count)
  );

  // S2: register the comparator result and accumulate its falsified literals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid     <= 1'b0;
      res_slice_idx <= '0;
      res_bitmask   <= '0;
      res_last      <= 1'b0;
      acc           <= '0;
    end else begin
      res_valid <= s1_valid;
      res_last  <= s1_valid && (s1_idx == LAST_ADDR);
      if (s1_valid) begin
        res_slice_idx <= s1_idx;
        res_bitmask   <= cmp_bitmask;
      end
      if (accept)        acc <= '0;
      else if (s1_valid) acc <= acc + CNT_BITS'(pop_count);
    end
  end

  // Per-clause summary: a clause is hit when any of its literals is falsified
  always_comb begin
    res_clause_hit = '0;
    for (int c = 0; c < NUM_CLAUSES_PER_CYCLE; c++) begin
      res_clause_hit[c] = |res_bitmask[c*NUM_VARS_PER_CLAUSE +: NUM_VARS_PER_CLAUSE];
    end
  end

endmodule

`default_nettype wire

// File: doc/clause_scanner.md
# clause_scanner

Sequencer that sits directly upstream of the `comparator` stage in the clause-evaluation path. It accepts one variable assignment per request and walks the clause memory slice by slice. Each slice, together with the latched assignment, is presented to the comparator. The block registers the comparator's falsified-literal bitmask into a result stream and reports a per-assignment falsified-literal count when the scan completes.

## Interface
Parameters:
- `NUM_CLAUSES`, 64, total clauses in memory; must be a multiple of `NUM_CLAUSES_PER_CYCLE`, otherwise elaboration fails.
- `VAR_ID_BITS`, 8, variable ID width.
- `NUM_CLAUSES_PER_CYCLE`, 16, clauses per memory slice.
- `NUM_VARS_PER_CLAUSE`, 3, literals per clause.
- Derived: `NUM_SLICES` = NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE; `ADDR_BITS` = max(1, clog2(NUM_SLICES)); `MEMORY_WIDTH` = (VAR_ID_BITS+1)·NUM_VARS_PER_CLAUSE·NUM_CLAUSES_PER_CYCLE; `BITMASK_WIDTH` = NUM_VARS_PER_CLAUSE·NUM_CLAUSES_PER_CYCLE; `CNT_BITS` = clog2(NUM_CLAUSES·NUM_VARS_PER_CLAUSE+1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: assignment request valid.
- `req_ready` out 1: high only in IDLE.
- `req_var_id` in VAR_ID_BITS: variable being assigned.
- `req_var_val` in 1: 0 = True, 1 = False.
- `mem_rd_en` out 1: clause-memory read strobe.
- `mem_rd_addr` out ADDR_BITS: slice index.
- `mem_rd_data` in MEMORY_WIDTH: slice data, valid the cycle after `mem_rd_en`.
- `cmp_var_id` out VAR_ID_BITS: registered assignment ID to the comparator.
- `cmp_var_val` out 1: registered assignment value to the comparator.
- `cmp_memory_slice` out MEMORY_WIDTH: registered slice to the comparator.
- `cmp_bitmask` in BITMASK_WIDTH: comparator output, combinational from the `cmp_*` signals.
- `res_valid` out 1: result beat valid; there is no backpressure.
- `res_slice_idx` out ADDR_BITS: slice index of the beat.
- `res_bitmask` out BITMASK_WIDTH: registered `cmp_bitmask`.
- `res_clause_hit` out NUM_CLAUSES_PER_CYCLE: bit c = OR of `res_bitmask[c·NUM_VARS_PER_CLAUSE +: NUM_VARS_PER_CLAUSE]`.
- `res_last` out 1: marks the final beat of a scan.
- `done` out 1: one-cycle pulse after the last beat.
- `hit_count` out CNT_BITS: total falsified literals for the scan; valid while `done` is high and held until the next accept.

## Operation
- Memory layout: literal j of clause c occupies bits [(c·NUM_VARS_PER_CLAUSE+j)·(VAR_ID_BITS+1) +: VAR_ID_BITS+1], ordered {neg, id}. The corresponding bitmask index is c·NUM_VARS_PER_CLAUSE+j.
- Accept: the handshake fires when `req_valid` and `req_ready` are both high. On accept the block latches `req_var_id` and `req_var_val` into `cmp_var_id` and `cmp_var_val`, clears the accumulator and enters READ.
- The block holds `cmp_var_id` and `cmp_var_val` until the next accept.
- FSM:
  - IDLE → READ on accept.
  - READ lasts NUM_SLICES cycles. `mem_rd_en` is high and `mem_rd_addr` steps 0..NUM_SLICES-1; the last address moves the FSM to DRAIN.
  - DRAIN lasts exactly 3 cycles, then → DONE.
  - DONE lasts 1 cycle with `done` high, then → IDLE.
- Pipeline: stage S1 registers `mem_rd_data` into `cmp_memory_slice`. Stage S2 registers `cmp_bitmask` into `res_bitmask`, sets `res_valid`, carries the index and sets `res_last` on index NUM_SLICES-1. S2 also adds popcount(`cmp_bitmask`) into the accumulator.
- `cmp_memory_slice` retains its last value when no read is in flight.
- Requests presented while busy are not accepted; `req_ready` stays low.

## Timing
- Cycle 0 is the accept edge.
- `mem_rd_addr` k is driven in cycle 1+k.
- `cmp_memory_slice` holds slice k in cycle 3+k.
- `res_valid` is high in cycles 4..NUM_SLICES+3; `res_last` is high in cycle NUM_SLICES+3.
- `done` is high in cycle NUM_SLICES+4. The earliest next accept is cycle NUM_SLICES+5.
- Reset values: `req_ready` 1 after reset release. All other outputs are 0: `mem_rd_en`, `mem_rd_addr`, `cmp_var_id`, `cmp_var_val`, `cmp_memory_slice`, `res_valid`, `res_slice_idx`, `res_bitmask`, `res_clause_hit`, `res_last`, `done`, `hit_count`.
- Reset mid-scan: the FSM returns to IDLE immediately and in-flight beats are discarded. No `done` is produced.
- NUM_SLICES = 1: the address is constantly 0, and `res_valid` and `res_last` coincide in cycle 4.
- Width rule: the accumulator is CNT_BITS wide. A full scan, maximally NUM_CLAUSES·NUM_VARS_PER_CLAUSE, cannot overflow.

## Structure
- Package `sat_pkg` holds the four base parameters, the derived widths, and the FSM state enum (IDLE, READ, DRAIN, DONE).
- Sub-module `bit_popcount`, parameterized by width, is used for the S2 accumulation.
- The comparator is instantiated beside this block at the next level up, not inside it.

## Test plan
In every scenario the bench instantiates the real comparator and a 1-cycle-latency memory model.
- Reset: with `rst_n` low, outputs take their reset values. After release, `req_ready`=1 and `mem_rd_en`=0.
- Single hit: slice 2, clause 0, literal 0 = {1, 5}, all other memory 0; request id 5, val 0. Required response: addresses 0..3 in cycles 1–4; beats in cycles 4–7. Beat idx 2 has `res_bitmask[0]`=1 and `res_clause_hit[0]`=1. `res_last` is high in cycle 7, `done` in cycle 8, `hit_count`=1.
- Multiple occurrences: slice 0 literals 0..2 = id 7 with neg 0, 1, 0; slice 3 clause 15 literal 2 = {1, 7}; request id 7, val 0. Required response: slice 0 bitmask bit 1 set; slice 3 bitmask bit 47 and `res_clause_hit[15]` set; `hit_count`=2.
- All falsified: memory all 0; request id 0, val 1. Required response: every beat has `res_bitmask` all ones; `hit_count`=192.
- Busy: hold `req_valid` high across two requests. Required response: the second accept occurs in cycle 9, and no accept happens in cycles 1–8.
- Reset mid-scan: drop `rst_n` in cycle 5. Required response: outputs go to 0 immediately with no `done`. A fresh request then yields a correct `hit_count` counted from 0.
